// File: rtl/syn_led_pwm_drv.sv
// syn_led_pwm_drv: NUM_CH-channel 8-bit LED PWM driver with double-buffered duty registers.
// Latency: duty write -> pending next cycle -> active at next frame boundary; led_od is one clock behind step/active state.
// Backpressure: none; writes are accepted every cycle, and out-of-range addresses are dropped. Optional macro SYN_LED_PWM_GAMMA_EN enables square-law gamma on writes.
module syn_led_pwm_drv #(
    parameter int NUM_CH   = 16,
    parameter int PRESCALE = 50
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    input  logic              en_ih,
    input  logic              duty_wr_ih,
    input  logic [3:0]        duty_addr_id,
    input  logic [7:0]        duty_data_id,
    output logic [NUM_CH-1:0] led_od,
    output logic              frame_tick_oh
);

    // Prescaler width; PRESCALE=1 still needs a 1-bit counter that simply stays at 0.
    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [7:0]        step_q, step_d;
    logic [7:0]        pend_q [NUM_CH];
    logic [7:0]        pend_d [NUM_CH];
    logic [7:0]        act_q  [NUM_CH];
    logic [7:0]        act_d  [NUM_CH];
    logic [NUM_CH-1:0] led_q, led_d;
    logic              frame_tick_q, frame_tick_d;

    logic              step_tick;
    logic              frame_bnd;
    logic              wr_hit;
    logic [7:0]        duty_eff;

`ifdef SYN_LED_PWM_GAMMA_EN
    logic [15:0]       duty_sq;

    // Gamma: keep the upper byte of the full 16-bit square.
    always_comb begin
        duty_sq  = duty_data_id * duty_data_id;
        duty_eff = duty_sq[15:8];
    end
`else
    // Linear mapping: the requested duty is stored unchanged.
    always_comb begin
        duty_eff = duty_data_id;
    end
`endif

    // Timebase: prescaler wraps at PRESCALE-1; the step counter advances on each wrap and
    // the frame boundary is the step tick taken while the step counter sits at 255.
    always_comb begin
        step_tick    = (presc_q == PRESC_MAX);
        presc_d      = step_tick ? '0 : presc_q + 1'b1;
        step_d       = step_tick ? step_q + 8'd1 : step_q;
        frame_bnd    = step_tick && (step_q == 8'hFF);
        frame_tick_d = frame_bnd;
    end

    // Duty registers: writes land in pending; active samples the pre-write pending copy at
    // the boundary, so a write coinciding with a boundary waits one more frame.
    always_comb begin
        wr_hit = duty_wr_ih && (int'(duty_addr_id) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            pend_d[i] = pend_q[i];
            act_d[i]  = frame_bnd ? pend_q[i] : act_q[i];
            if (wr_hit && (duty_addr_id == 4'(i))) begin
                pend_d[i] = duty_eff;
            end
        end
    end

    // PWM compare: strict less-than, so duty 0 is always off and 255 is on for 255/256 steps.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            led_d[i] = en_ih && (step_q < act_q[i]);
        end
    end

    // State update; reset also swallows any write strobe presented in the same cycle.
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            presc_q      <= '0;
            step_q       <= '0;
            led_q        <= '0;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            presc_q      <= presc_d;
            step_q       <= step_d;
            led_q        <= led_d;
            frame_tick_q <= frame_tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
            end
        end
    end

    // Output bus is exactly NUM_CH wide, so there are no unused upper channels to drive.
    assign led_od        = led_q;
    assign frame_tick_oh = frame_tick_q;

endmodule

// File: tb/tb_syn_led_pwm_drv.sv
// Bench for syn_led_pwm_drv with NUM_CH=8, PRESCALE=2 (frame = 512 clocks).
// Expected per-frame on-clock counts and tick periods are queued as stimulus is issued;
// a monitor accumulates led_od between frame ticks and checks each frame against the queue.
module tb_syn_led_pwm_drv;
    localparam int NUM_CH   = 8;
    localparam int PRESCALE = 2;
`ifdef SYN_LED_PWM_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic              clk_ir = 1'b0;
    logic              rst_ih;
    logic              en_ih;
    logic              duty_wr_ih;
    logic [3:0]        duty_addr_id;
    logic [7:0]        duty_data_id;
    logic [NUM_CH-1:0] led_od;
    logic              frame_tick_oh;

    int n_vec = 0;
    int n_err = 0;
    // Per frame: tick period, then NUM_CH on-clock counts.
    int exp_q[$];

    syn_led_pwm_drv #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE)) dut (
        .clk_ir       (clk_ir),
        .rst_ih       (rst_ih),
        .en_ih        (en_ih),
        .duty_wr_ih   (duty_wr_ih),
        .duty_addr_id (duty_addr_id),
        .duty_data_id (duty_data_id),
        .led_od       (led_od),
        .frame_tick_oh(frame_tick_oh)
    );

    always #5 clk_ir = ~clk_ir;

    function automatic int pick(input int dflt, input int gam);
        return GAMMA ? gam : dflt;
    endfunction

    task automatic check(input string name, input int ch, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", name, ch, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int p, input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input int c6, input int c7);
        exp_q.push_back(p);
        exp_q.push_back(c0); exp_q.push_back(c1); exp_q.push_back(c2); exp_q.push_back(c3);
        exp_q.push_back(c4); exp_q.push_back(c5); exp_q.push_back(c6); exp_q.push_back(c7);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_ir);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        duty_wr_ih   = 1'b1;
        duty_addr_id = 4'(addr);
        duty_data_id = 8'(data);
        cyc(1);
        duty_wr_ih   = 1'b0;
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 1200; k++) begin
            @(posedge clk_ir);
            #1;
            if (frame_tick_oh) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL wait_tick: got no frame_tick_oh, expected one within 1200 clocks");
    endtask

    // Monitor: count lit clocks per channel since the last tick/reset, compare at each tick.
    initial begin
        int since;
        int cnt [NUM_CH];
        int e;
        since = 0;
        for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        forever begin
            @(negedge clk_ir);
            since++;
            for (int c = 0; c < NUM_CH; c++) cnt[c] += int'(led_od[c]);
            if (rst_ih) begin
                since = 0;
                for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
            end else if (frame_tick_oh) begin
                if (exp_q.size() < NUM_CH + 1) begin
                    check("unexpected_frame", 0, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_period", 0, since, e);
                    for (int c = 0; c < NUM_CH; c++) begin
                        e = exp_q.pop_front();
                        check("on_clocks", c, cnt[c], e);
                    end
                end
                since = 0;
                for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end before 200000 ns");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ih = 1'b1; en_ih = 1'b1; duty_wr_ih = 1'b0; duty_addr_id = '0; duty_data_id = '0;
        // Frame 1 (from reset): nothing active. Frame 2: only ch3 = 64.
        push_frame(513, 0, 0, 0, 0, 0, 0, 0, 0);
        push_frame(512, 0, 0, 0, pick(128, 32), 0, 0, 0, 0);
        cyc(1);
        check("reset_led", 0, int'(led_od), 0);
        check("reset_tick", 0, int'(frame_tick_oh), 0);
        cyc(3);
        rst_ih = 1'b0;
        wr(3, 64);
        wr(15, 99);                       // out of range for 8 channels
        wait_tick();                      // F1

        cyc(10);
        wr(0, 50);
        wr(1, 77);
        wr(1, 0);                         // last write wins
        wr(2, 255);
        wr(4, 128);
        wr(5, 16);
        wr(6, 15);
        wr(7, 255);
        push_frame(512, pick(100, 18), 0, pick(510, 508), pick(128, 32),
                   pick(256, 128), pick(32, 2), pick(30, 0), pick(510, 508));
        wait_tick();                      // F2

        cyc(100);
        wr(0, 200);                       // mid-frame: ch0 stays 50 for this frame
        push_frame(512, pick(400, 312), 0, pick(510, 508), pick(128, 32),
                   pick(256, 128), pick(32, 2), pick(30, 0), pick(510, 508));
        cyc(410);
        wr(1, 100);                       // sampled on the frame boundary edge
        check("bnd_write_on_tick", 0, int'(frame_tick_oh), 1);
        push_frame(512, pick(400, 312), pick(200, 78), pick(60, 6), pick(128, 32),
                   pick(256, 128), pick(32, 2), pick(30, 0), pick(510, 508));
        cyc(20);
        wr(2, 10);
        wr(2, 30);
        wr(15, 0);
        wait_tick();                      // F4
        wait_tick();                      // F5

        en_ih = 1'b0;
        push_frame(512, pick(100, 12), 0, 0, 0, 0, 0, 0, pick(210, 208));
        cyc(300);
        en_ih = 1'b1;
        wait_tick();                      // F6

        cyc(100);
        push_frame(513, 0, 0, 0, 0, 0, 0, 0, 0);
        push_frame(512, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_ih       = 1'b1;
        duty_wr_ih   = 1'b1;              // must be ignored under reset
        duty_addr_id = 4'd4;
        duty_data_id = 8'd200;
        cyc(3);
        rst_ih     = 1'b0;
        duty_wr_ih = 1'b0;
        check("midreset_led", 0, int'(led_od), 0);
        check("midreset_tick", 0, int'(frame_tick_oh), 0);
        wait_tick();
        wait_tick();
        @(negedge clk_ir);
        #1;
        check("queue_drained", 0, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
